// File: rtl/poly_pkg.sv
// ============================================================================
// Module  : poly_pkg
// Brief   : Shared widths and FSM state type for the polynomial multiplier.
//           State RED exists only when POLY_MUL_FUSED_RED_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

package poly_pkg;

    localparam int COEF_W = 8;
    localparam int N_IN   = 5;
    localparam int N_OUT  = 9;

`ifdef POLY_MUL_FUSED_RED_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2,
        ST_RED  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
`endif

endpackage

`default_nettype wire

// File: rtl/poly_mac_row.sv
// ============================================================================
// Module  : poly_mac_row
// Brief   : Combinational MAC row: sum[j] = acc[j] + a_i*b[j], mod 2^COEF_W.
// Revision: 1.0
// ============================================================================
`default_nettype none

module poly_mac_row
    import poly_pkg::*;
(
    input  logic [COEF_W-1:0] a_i,
    input  logic [COEF_W-1:0] b   [N_IN],
    input  logic [COEF_W-1:0] acc [N_IN],
    output logic [COEF_W-1:0] sum [N_IN]
);

    for (genvar j = 0; j < N_IN; j++) begin : g_col
        assign sum[j] = acc[j] + a_i * b[j];
    end

endmodule

`default_nettype wire

// File: rtl/poly_mul_stage1.sv
// ============================================================================
// Module  : poly_mul_stage1
// Brief   : Sequential 5x5-coefficient polynomial multiplier, one A row per
//           cycle. Optional fused reduction stage: POLY_MUL_FUSED_RED_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module poly_mul_stage1
    import poly_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [COEF_W-1:0] a0,
    input  logic [COEF_W-1:0] a1,
    input  logic [COEF_W-1:0] a2,
    input  logic [COEF_W-1:0] a3,
    input  logic [COEF_W-1:0] a4,
    input  logic [COEF_W-1:0] b0,
    input  logic [COEF_W-1:0] b1,
    input  logic [COEF_W-1:0] b2,
    input  logic [COEF_W-1:0] b3,
    input  logic [COEF_W-1:0] b4,
    output logic              busy,
    output logic              done,
    output logic [COEF_W-1:0] s0,
    output logic [COEF_W-1:0] s1,
    output logic [COEF_W-1:0] s2,
    output logic [COEF_W-1:0] s3,
    output logic [COEF_W-1:0] s4,
    output logic [COEF_W-1:0] s5,
    output logic [COEF_W-1:0] s6,
    output logic [COEF_W-1:0] s7,
    output logic [COEF_W-1:0] s8
`ifdef POLY_MUL_FUSED_RED_EN
    ,
    output logic [COEF_W-1:0] c0,
    output logic [COEF_W-1:0] c1,
    output logic [COEF_W-1:0] c2,
    output logic [COEF_W-1:0] c3,
    output logic [COEF_W-1:0] c4
`endif
);

    state_t            r_state;
    logic [2:0]        r_cnt;
    logic [COEF_W-1:0] r_a   [N_IN];
    logic [COEF_W-1:0] r_b   [N_IN];
    logic [COEF_W-1:0] r_acc [N_OUT];
    logic [COEF_W-1:0] r_s   [N_OUT];

    logic [COEF_W-1:0] w_a_in     [N_IN];
    logic [COEF_W-1:0] w_b_in     [N_IN];
    logic [COEF_W-1:0] w_slice    [N_IN];
    logic [COEF_W-1:0] w_sum      [N_IN];
    logic [COEF_W-1:0] w_acc_next [N_OUT];
    logic [3:0]        w_idx      [N_IN];
    logic [COEF_W-1:0] w_a_i;

    assign w_a_in = '{a0, a1, a2, a3, a4};
    assign w_b_in = '{b0, b1, b2, b3, b4};
    assign w_a_i  = r_a[r_cnt];

    // Row i touches accumulator window acc[i .. i+4]
    for (genvar j = 0; j < N_IN; j++) begin : g_win
        assign w_idx[j]   = {1'b0, r_cnt} + 4'(j);
        assign w_slice[j] = r_acc[w_idx[j]];
    end

    poly_mac_row u_row (
        .a_i (w_a_i),
        .b   (r_b),
        .acc (w_slice),
        .sum (w_sum)
    );

    always_comb begin
        w_acc_next = r_acc;
        for (int j = 0; j < N_IN; j++) begin
            w_acc_next[w_idx[j]] = w_sum[j];
        end
    end

`ifdef POLY_MUL_FUSED_RED_EN
    logic [COEF_W-1:0] r_c [N_IN];
    assign c0 = r_c[0];
    assign c1 = r_c[1];
    assign c2 = r_c[2];
    assign c3 = r_c[3];
    assign c4 = r_c[4];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            for (int k = 0; k < N_IN; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
`ifdef POLY_MUL_FUSED_RED_EN
                r_c[k] <= '0;
`endif
            end
            for (int k = 0; k < N_OUT; k++) begin
                r_acc[k] <= '0;
                r_s[k]   <= '0;
            end
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= w_a_in;
                        r_b     <= w_b_in;
                        r_cnt   <= 3'd0;
                        busy    <= 1'b1;
                        r_state <= ST_MAC;
                        for (int k = 0; k < N_OUT; k++) begin
                            r_acc[k] <= '0;
                        end
                    end
                end
                ST_MAC: begin
                    r_acc <= w_acc_next;
                    if (r_cnt == 3'(N_IN - 1)) begin
                        r_cnt   <= 3'd0;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                ST_DONE: begin
                    r_s <= r_acc;
`ifdef POLY_MUL_FUSED_RED_EN
                    r_state <= ST_RED;
`else
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
`endif
                end
`ifdef POLY_MUL_FUSED_RED_EN
                ST_RED: begin
                    r_c[0]  <= r_s[0] - r_s[5] - r_s[6];
                    r_c[1]  <= r_s[1] - r_s[6];
                    r_c[2]  <= r_s[2] - r_s[7] - r_s[5] - r_s[8];
                    r_c[3]  <= r_s[3] - r_s[8] - r_s[6];
                    r_c[4]  <= r_s[4] - r_s[7];
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
`endif
                default: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s0 = r_s[0];
    assign s1 = r_s[1];
    assign s2 = r_s[2];
    assign s3 = r_s[3];
    assign s4 = r_s[4];
    assign s5 = r_s[5];
    assign s6 = r_s[6];
    assign s7 = r_s[7];
    assign s8 = r_s[8];

endmodule

`default_nettype wire

// File: doc/poly_mul_stage1.md
POLY_MUL_STAGE1 -- requirements
Module: poly_mul_stage1

Interface
REQ-001 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-002 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port start, input, 1 bit: operand-valid strobe, sampled in IDLE only.
REQ-004 SHALL have ports a0..a4, input, 8 bits each: operand A coefficients, a0 lowest order.
REQ-005 SHALL have ports b0..b4, input, 8 bits each: operand B coefficients, b0 lowest order.
REQ-006 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse when results become valid.
REQ-008 SHALL have ports s0..s8, output, 8 bits each: registered product coefficients, s0 lowest order.

Function
REQ-009 SHALL compute s[k] = sum over i+j=k of a_i*b_j, truncated mod 256 (8-bit wrap, no saturation, unsigned).
REQ-010 SHALL implement states IDLE, MAC, DONE (plus RED under REQ-022).
REQ-011 SHALL, in IDLE with start=1 at edge T, latch a0..a4 and b0..b4, clear accumulators, and enter MAC.
REQ-012 SHALL, in MAC, process one A coefficient per cycle with a 3-bit row counter i=0..4: add a_i*b_j into acc[i+j] for all j in parallel.
REQ-013 SHALL leave MAC after row 4, i.e. after exactly 5 MAC cycles, and enter DONE.
REQ-014 SHALL, in DONE, copy acc to s0..s8, pulse done for one cycle, and return to IDLE; start at edge T gives done high in cycle T+6.
REQ-015 SHALL hold s0..s8 stable from done until the next done; there are no partial updates during MAC.
REQ-016 SHALL ignore start while busy=1; the in-flight operation is unaffected.
REQ-017 SHALL accept start in the cycle immediately after done, i.e. in IDLE, giving back-to-back throughput of one result per 7 cycles.
REQ-018 SHALL ignore operand port changes after the latch edge.

Reset
REQ-019 SHALL, when reset=1 at a clock edge, force IDLE, counter=0, acc=0, s0..s8=0, done=0, busy=0.
REQ-020 SHALL, on reset during MAC or DONE, abort the operation with no done pulse, and SHALL drive s0..s8 to 0.
REQ-021 SHALL give reset priority over start in the same cycle.

Configuration
REQ-022 SHALL, with POLY_MUL_FUSED_RED_EN defined, add 8-bit outputs c0..c4 and a RED state between DONE-copy and done, making done high at T+7.
REQ-023 SHALL, in RED, register c0=s0-s5-s6, c1=s1-s6, c2=s2-s7-s5-s8, c3=s3-s8-s6, c4=s4-s7, all mod 256; c0..c4 SHALL reset to 0.
REQ-024 SHALL, without POLY_MUL_FUSED_RED_EN, have no c ports, no RED state, and the latency of REQ-014.

Structure
REQ-025 SHALL take COEF_W=8, N_IN=5, N_OUT=9 and the state enum from shared package poly_pkg.
REQ-026 SHALL instantiate one sub-module poly_mac_row: inputs a_i, b0..b4 and acc slice; outputs the 5 updated sums; purely combinational.
REQ-027 SHALL use no multicycle paths; the one-cycle MAC row is the critical path.

Verification
REQ-028 Bench SHALL check: a=(1,0,0,0,0), b=(3,4,5,6,7), start -> done at T+6, s=(3,4,5,6,7,0,0,0,0).
REQ-029 Bench SHALL check: a=b=(1,1,1,1,1) -> s=(1,2,3,4,5,4,3,2,1); with POLY_MUL_FUSED_RED_EN, c=(250,255,252,0,3) at T+7.
REQ-030 Bench SHALL check: a0=b0=255, all else 0 -> s0=1 (wrap), s1..s8=0.
REQ-031 Bench SHALL check: start pulsed at T+2 during MAC with different operands -> ignored; first result unchanged; single done pulse.
REQ-032 Bench SHALL check: reset asserted at T+3 -> no done pulse, s=0, busy=0 next cycle; a new start then gives a correct result.
REQ-033 Bench SHALL check: start held high continuously -> results at T+6, T+13, T+20, each matching the latched operands.
